// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory access controller.
package dmem_pkg;

    localparam int D_WIDTH = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        RESP   = 2'b11
    } state_t;

    // 1 when the size code is legal and the low address bits suit it.
    function automatic logic size_aligned(size_t size, logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~lo[0];
            SZ_WORD: return (lo == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Requester and data-memory buses of the access controller.
interface dmem_access_ctrl_if
    import dmem_pkg::*;
#(
    parameter int A_WIDTH = 28
);
    logic [1:0]                     req_valid;
    logic [1:0]                     req_ready;
    logic [1:0]                     req_we;
    logic [1:0][1:0]                req_size;
    logic [1:0]                     req_unsigned;
    logic [1:0][A_WIDTH-1:0]        req_addr;
    logic [1:0][D_WIDTH-1:0]        req_wdata;
    logic [1:0]                     resp_valid;
    logic                           resp_err;
    logic [D_WIDTH-1:0]             resp_rdata;
    logic [A_WIDTH-1:0]             mem_A;
    logic [D_WIDTH-1:0]             mem_WD;
    logic                           mem_WE;
    logic [D_WIDTH-1:0]             mem_RD;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_RD,
        input  req_ready, resp_valid, resp_err, resp_rdata, mem_A, mem_WD, mem_WE
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_RD,
        output req_ready, resp_valid, resp_err, resp_rdata, mem_A, mem_WD, mem_WE
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Big-endian lane handling: load extract/extend and sub-word store merge.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_t              size,
    input  logic               uns,
    input  logic [1:0]         off,
    input  logic [D_WIDTH-1:0] rd,
    input  logic [15:0]        wdata,
    output logic [D_WIDTH-1:0] ld_data,
    output logic [D_WIDTH-1:0] merged
);
    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        case (off)
            2'd0:    bsel = rd[31:24];
            2'd1:    bsel = rd[23:16];
            2'd2:    bsel = rd[15:8];
            default: bsel = rd[7:0];
        endcase
        hsel    = off[1] ? rd[15:0] : rd[31:16];
        ld_data = rd;
        merged  = rd;
        case (size)
            SZ_BYTE: begin
                ld_data = {{24{bsel[7] & ~uns}}, bsel};
                case (off)
                    2'd0:    merged[31:24] = wdata[7:0];
                    2'd1:    merged[23:16] = wdata[7:0];
                    2'd2:    merged[15:8]  = wdata[7:0];
                    default: merged[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                ld_data = {{16{hsel[15] & ~uns}}, hsel};
                if (off[1]) merged[15:0]  = wdata;
                else        merged[31:16] = wdata;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/dmem_access_ctrl.sv
// Two-port round-robin sequencer for the big-endian word-wide data memory.
//   state  | meaning
//   IDLE   | waiting for a request; req_ready asserted for the granted port
//   ACCESS | memory addressed; load captured, word store written, or merge built
//   WRITE  | merged sub-word store written back
//   RESP   | one-cycle response strobe to the last granted port
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int A_WIDTH = 28
) (
    input  logic              CLK,
    input  logic              RST_N,
    dmem_access_ctrl_if.slave bus
);
    state_t             state, state_nx;
    logic               last_gnt, gnt, grant;
    logic               lat_we, lat_uns;
    size_t              lat_size;
    logic [A_WIDTH-1:0] lat_addr;
    logic [15:0]        lat_wdata;
    logic [D_WIDTH-1:0] mem_wd_q, rdata_q, ld_data, st_merged;
    logic               err_q, aligned, sub_store, we;
    logic [1:0]         ready, rvalid;

    assign aligned   = size_aligned(lat_size, lat_addr[1:0]);
    assign sub_store = lat_we && (lat_size != SZ_WORD);

    always_comb begin
        grant = 1'b0;
        gnt   = 1'b0;
        if (state == IDLE) begin
            case (bus.req_valid)
                2'b01:   grant = 1'b1;
                2'b10:   begin grant = 1'b1; gnt = 1'b1; end
                2'b11:   begin grant = 1'b1; gnt = ~last_gnt; end
                default: ;
            endcase
        end
    end

    // mem_WE depends only on registered state, so async reset kills it at once.
    always_comb begin
        state_nx = state;
        ready    = '0;
        rvalid   = '0;
        we       = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    ready[gnt] = 1'b1;
                    state_nx   = ACCESS;
                end
            end
            ACCESS: begin
                state_nx = RESP;
                if (aligned && sub_store) state_nx = WRITE;
                else if (aligned && lat_we) we = 1'b1;
            end
            WRITE: begin
                we       = 1'b1;
                state_nx = RESP;
            end
            RESP: begin
                rvalid[last_gnt] = 1'b1;
                state_nx         = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_gnt  <= 1'b1;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= SZ_BYTE;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant) begin
            last_gnt  <= gnt;
            lat_we    <= bus.req_we[gnt];
            lat_uns   <= bus.req_unsigned[gnt];
            lat_size  <= size_t'(bus.req_size[gnt]);
            lat_addr  <= bus.req_addr[gnt];
            lat_wdata <= bus.req_wdata[gnt][15:0];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_wd_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (grant && bus.req_we[gnt] && (size_t'(bus.req_size[gnt]) == SZ_WORD))
                mem_wd_q <= bus.req_wdata[gnt];
            if (state == ACCESS) begin
                if (aligned && sub_store) mem_wd_q <= st_merged;
                err_q   <= ~aligned;
                rdata_q <= (aligned && !lat_we) ? ld_data : '0;
            end
        end
    end

    dmem_lane_align u_lane (
        .size    (lat_size),
        .uns     (lat_uns),
        .off     (lat_addr[1:0]),
        .rd      (bus.mem_RD),
        .wdata   (lat_wdata),
        .ld_data (ld_data),
        .merged  (st_merged)
    );

    assign bus.req_ready  = ready;
    assign bus.resp_valid = rvalid;
    assign bus.resp_err   = err_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_A      = {lat_addr[A_WIDTH-1:2], 2'b00};
    assign bus.mem_WD     = mem_wd_q;
    assign bus.mem_WE     = we;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: byte-level reference model, directed pins, random traffic.
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    localparam int AW = 28;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    dmem_access_ctrl_if #(.A_WIDTH(AW)) bus();
    dmem_access_ctrl #(.A_WIDTH(AW)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus.slave));

    logic [31:0] dmem [256];
    logic [7:0]  ref_mem [1024];
    logic        bd_we = 1'b0;
    int          bd_idx = 0;
    logic [31:0] bd_word = '0;
    int          n_checks = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;

    always_comb bus.mem_RD = dmem[bus.mem_A[9:2]];

    always @(posedge CLK) begin
        if (bus.mem_WE) dmem[bus.mem_A[9:2]] <= bus.mem_WD;
        if (bd_we) dmem[bd_idx[7:0]] <= bd_word;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_busy = 1'b0;
    bit          m_last = 1'b1;
    bit          m_err, m_hasw;
    int          m_t, m_lat, m_wecyc, m_port, m_base;
    logic [31:0] m_rdata, m_word;
    logic [1:0]  c_exp;
    int          c_p;

    function automatic logic [31:0] rd_bytes(input int a, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[(a + i) % 1024]);
        return v;
    endfunction

    task automatic model_accept(input int p);
        int a, sz, nb;
        bit ok, we, uns;
        logic [31:0] wd, v;
        logic [7:0] tb4 [4];
        a   = int'(bus.req_addr[p][9:0]);
        sz  = int'(bus.req_size[p]);
        we  = bus.req_we[p];
        uns = bus.req_unsigned[p];
        wd  = bus.req_wdata[p];
        ok  = (sz == 0) || (sz == 1 && a % 2 == 0) || (sz == 2 && a % 4 == 0);
        nb  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        m_port = p; m_last = (p == 1); m_busy = 1'b1; m_t = 0;
        m_err = !ok; m_rdata = '0; m_hasw = 1'b0; m_base = a - a % 4;
        m_lat = 2; m_wecyc = 0; m_word = '0;
        if (ok && !we) begin
            v = rd_bytes(a, nb);
            if (nb == 1)      m_rdata = uns ? v : {{24{v[7]}}, v[7:0]};
            else if (nb == 2) m_rdata = uns ? v : {{16{v[15]}}, v[15:0]};
            else              m_rdata = v;
        end else if (ok && we) begin
            for (int i = 0; i < 4; i++) tb4[i] = ref_mem[m_base + i];
            for (int i = 0; i < nb; i++) tb4[a % 4 + i] = 8'(wd >> (8 * (nb - 1 - i)));
            m_word  = {tb4[0], tb4[1], tb4[2], tb4[3]};
            m_hasw  = 1'b1;
            m_wecyc = (nb == 4) ? 1 : 2;
            m_lat   = (nb == 4) ? 2 : 3;
        end
    endtask

    always @(negedge CLK) begin
        if (bd_we)
            for (int i = 0; i < 4; i++) ref_mem[bd_idx * 4 + i] = bd_word[31 - 8 * i -: 8];
        if (!RST_N) begin
            m_busy = 1'b0;
            m_last = 1'b1;
        end else if (chk_en) begin
            if (!m_busy) begin
                c_p = -1;
                if (bus.req_valid == 2'b01)      c_p = 0;
                else if (bus.req_valid == 2'b10) c_p = 1;
                else if (bus.req_valid == 2'b11) c_p = m_last ? 0 : 1;
                c_exp = '0;
                if (c_p >= 0) c_exp[c_p] = 1'b1;
                chk("req_ready", 32'(bus.req_ready), 32'(c_exp));
                chk("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
                chk("idle_mem_WE", 32'(bus.mem_WE), 32'd0);
                if (c_p >= 0) model_accept(c_p);
            end else begin
                m_t++;
                chk("busy_req_ready", 32'(bus.req_ready), 32'd0);
                chk("mem_WE", 32'(bus.mem_WE), 32'(m_hasw && m_t == m_wecyc));
                if (m_t == 1) chk("mem_A", 32'(bus.mem_A), 32'(m_base));
                if (m_hasw && m_t == m_wecyc) chk("mem_WD", bus.mem_WD, m_word);
                if (m_t == m_lat) begin
                    c_exp = '0;
                    c_exp[m_port] = 1'b1;
                    chk("resp_valid", 32'(bus.resp_valid), 32'(c_exp));
                    chk("resp_err", 32'(bus.resp_err), 32'(m_err));
                    chk("resp_rdata", bus.resp_rdata, m_rdata);
                    if (m_hasw)
                        for (int i = 0; i < 4; i++) ref_mem[m_base + i] = m_word[31 - 8 * i -: 8];
                    m_busy = 1'b0;
                end else begin
                    chk("busy_resp_valid", 32'(bus.resp_valid), 32'd0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bd_set(input int idx, input logic [31:0] w);
        @(posedge CLK); #1;
        bd_we = 1'b1; bd_idx = idx; bd_word = w;
    endtask

    task automatic bd_done();
        @(posedge CLK); #1;
        bd_we = 1'b0;
    endtask

    task automatic set_req(input int p, input bit we, input logic [1:0] sz, input bit uns,
                           input int addr, input logic [31:0] wd);
        bus.req_we[p]       = we;
        bus.req_size[p]     = sz;
        bus.req_unsigned[p] = uns;
        bus.req_addr[p]     = AW'(addr);
        bus.req_wdata[p]    = wd;
        bus.req_valid[p]    = 1'b1;
    endtask

    task automatic wait_accept(input int p);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 20) begin
            @(negedge CLK);
            acc = bus.req_ready[p];
            n++;
        end
        chk("accepted_in_time", 32'(acc), 32'd1);
        @(posedge CLK); #1;
        bus.req_valid[p] = 1'b0;
    endtask

    task automatic issue(input int p, input bit we, input logic [1:0] sz, input bit uns,
                         input int addr, input logic [31:0] wd,
                         output logic [31:0] rd, output bit err, output int lat, output int wes);
        bit got = 1'b0;
        @(posedge CLK); #1;
        set_req(p, we, sz, uns, addr, wd);
        wait_accept(p);
        lat = 0; wes = 0; rd = 'x; err = 1'bx;
        while (!got && lat < 10) begin
            @(negedge CLK);
            lat++;
            wes += int'(bus.mem_WE);
            if (bus.resp_valid[p]) begin
                got = 1'b1;
                rd  = bus.resp_rdata;
                err = bus.resp_err;
            end
        end
    endtask

    task automatic reset_vals_check();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_mem_WE", 32'(bus.mem_WE), 32'd0);
        chk("rst_mem_A", 32'(bus.mem_A), 32'd0);
        chk("rst_mem_WD", bus.mem_WD, 32'd0);
    endtask

    task automatic rand_req(input int p);
        int r, sz, a;
        r  = $urandom_range(0, 15);
        sz = (r == 0) ? 3 : r % 3;
        a  = $urandom_range(0, 1023);
        if (sz < 3 && $urandom_range(0, 4) != 0) a = a & ~((1 << sz) - 1);
        set_req(p, 1'($urandom_range(0, 1)), 2'(sz), 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd;
        bit          err;
        int          lat, wes, mism;
        logic [1:0]  acc, rvs;
        int          cnt [2];
        int          rcnt [2];
        int          order [$];

        bus.req_valid = '0; bus.req_we = '0; bus.req_size = '0; bus.req_unsigned = '0;
        bus.req_addr = '0; bus.req_wdata = '0;

        for (int i = 0; i < 256; i++) bd_set(i, $urandom);
        bd_set(4, 32'h11223344);
        bd_set(8, 32'hAABBCCDD);
        bd_set(12, 32'h01020304);
        bd_done();
        reset_vals_check();
        @(negedge CLK); #2;
        RST_N = 1'b1;
        chk_en = 1'b1;

        issue(0, 1'b0, 2'b10, 1'b0, 'h10, '0, rd, err, lat, wes);
        chk("ldw_rdata", rd, 32'h11223344);
        chk("ldw_lat", 32'(lat), 32'd2);
        chk("ldw_err", 32'(err), 32'd0);

        bd_set(4, 32'h11223380);
        bd_done();
        issue(1, 1'b0, 2'b00, 1'b0, 'h13, '0, rd, err, lat, wes);
        chk("ldb_signed", rd, 32'hFFFFFF80);
        chk("ldb_lat", 32'(lat), 32'd2);
        issue(1, 1'b0, 2'b00, 1'b1, 'h13, '0, rd, err, lat, wes);
        chk("ldb_unsigned", rd, 32'h00000080);

        issue(0, 1'b1, 2'b01, 1'b0, 'h22, 32'h0000BEEF, rd, err, lat, wes);
        chk("sth_lat", 32'(lat), 32'd3);
        chk("sth_we_cycles", 32'(wes), 32'd1);
        chk("sth_rdata", rd, 32'd0);
        chk("sth_word", dmem[8], 32'hAABBBEEF);

        issue(0, 1'b1, 2'b10, 1'b0, 'h21, 32'h12345678, rd, err, lat, wes);
        chk("misal_err", 32'(err), 32'd1);
        chk("misal_lat", 32'(lat), 32'd2);
        chk("misal_we_cycles", 32'(wes), 32'd0);
        chk("misal_mem_kept", dmem[8], 32'hAABBBEEF);

        issue(1, 1'b0, 2'b01, 1'b0, 'h22, '0, rd, err, lat, wes);
        chk("ldh_signed", rd, 32'hFFFFBEEF);
        issue(0, 1'b0, 2'b11, 1'b0, 'h20, '0, rd, err, lat, wes);
        chk("size11_err", 32'(err), 32'd1);
        chk("size11_rdata", rd, 32'd0);

        // reset while the merged byte store sits in WRITE
        @(posedge CLK); #1;
        set_req(0, 1'b1, 2'b00, 1'b0, 'h31, 32'h0000005A);
        wait_accept(0);
        @(negedge CLK);
        @(negedge CLK);
        chk("we_in_write", 32'(bus.mem_WE), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("we_async_drop", 32'(bus.mem_WE), 32'd0);
        rvs = '0;
        repeat (3) begin
            @(negedge CLK);
            rvs |= bus.resp_valid;
        end
        chk("no_resp_after_reset", 32'(rvs), 32'd0);
        chk("word_0x30_kept", dmem[12], 32'h01020304);
        reset_vals_check();
        @(negedge CLK); #2;
        RST_N = 1'b1;

        // both ports requesting back to back
        cnt = '{0, 0};
        rcnt = '{0, 0};
        @(posedge CLK); #1;
        set_req(0, 1'b0, 2'b10, 1'b0, 'h40, '0);
        set_req(1, 1'b0, 2'b10, 1'b0, 'h80, '0);
        for (int cyc = 0; cyc < 80 && (rcnt[0] < 3 || rcnt[1] < 3); cyc++) begin
            @(negedge CLK);
            acc = bus.req_ready & bus.req_valid;
            for (int p = 0; p < 2; p++) begin
                if (bus.resp_valid[p]) rcnt[p]++;
                if (acc[p]) begin
                    order.push_back(p);
                    cnt[p]++;
                end
            end
            @(posedge CLK); #1;
            for (int p = 0; p < 2; p++)
                if (acc[p]) begin
                    if (cnt[p] < 3) set_req(p, 1'b0, 2'b10, 1'b0, 'h40 * (p + 1) + 4 * cnt[p], '0);
                    else            bus.req_valid[p] = 1'b0;
                end
        end
        chk("grant_count", 32'(order.size()), 32'd6);
        foreach (order[i]) chk("grant_order", 32'(order[i]), 32'(i % 2));
        chk("resp_count_p0", 32'(rcnt[0]), 32'd3);
        chk("resp_count_p1", 32'(rcnt[1]), 32'd3);

        // random traffic, requests held until granted or occasionally withdrawn
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge CLK);
            acc = bus.req_ready & bus.req_valid;
            @(posedge CLK); #1;
            for (int p = 0; p < 2; p++) begin
                if (bus.req_valid[p] && !acc[p]) begin
                    if ($urandom_range(0, 15) == 0) bus.req_valid[p] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    rand_req(p);
                end else begin
                    bus.req_valid[p] = 1'b0;
                end
            end
        end
        bus.req_valid = '0;
        repeat (6) @(negedge CLK);

        mism = 0;
        for (int w = 0; w < 256; w++)
            if (dmem[w] !== {ref_mem[4 * w], ref_mem[4 * w + 1], ref_mem[4 * w + 2], ref_mem[4 * w + 3]})
                mism++;
        chk("mem_final_mismatch_words", 32'(mism), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
